// File: rtl/seq_ripple_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock through a ripple of full-adder cells, low chunk first.
// Latency: done pulses in the cycle after edge k+N (N = WIDTH/CHUNK) when start is accepted at edge k.
// Backpressure: start is only sampled while busy=0; requests during RUN are dropped. SEQ_RIPPLE_ADDER_OVF_EN enables ovf.
module seq_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    // Number of compute cycles and the chunk counter sized to index them (at least one bit).
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST_CHUNK = CW'(N - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             c_out_q, c_out_d;

    // Chunk datapath signals: the operand slice selected by the counter and its ripple chain.
    int               base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic [CHUNK:0]   rc;
    logic             last_chunk;
    logic [WIDTH-1:0] sum_merged;

`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Ripple CHUNK full-adder cells over the current slice; rc[j] is the carry into bit j of the chunk.
    always_comb begin
        base       = int'(cnt_q) * CHUNK;
        a_chunk    = CHUNK'(a_q >> base);
        b_chunk    = CHUNK'(b_q >> base);
        sum_chunk  = '0;
        rc         = '0;
        rc[0]      = carry_q;
        for (int j = 0; j < CHUNK; j++) begin
            sum_chunk[j] = a_chunk[j] ^ b_chunk[j] ^ rc[j];
            rc[j+1]      = ((a_chunk[j] ^ b_chunk[j]) & rc[j]) | (a_chunk[j] & b_chunk[j]);
        end
        last_chunk = (cnt_q == LAST_CHUNK);
        // Replace only the slice being computed; other slices keep their current contents.
        sum_merged = (sum_q & ~(CHUNK_MASK << base)) | (WIDTH'(sum_chunk) << base);
    end

    // Next-state and datapath update for the IDLE/RUN controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        c_out_d = c_out_q;
        done_d  = 1'b0;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The done cycle is IDLE, so a start there chains straight into the next operation.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = sum_merged;
                carry_d = rc[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) begin
                    c_out_d = rc[CHUNK];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    ovf_d   = rc[CHUNK-1] ^ rc[CHUNK];
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            c_out_q <= c_out_d;
        end
    end

`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    // Overflow flag register, updated on the same edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy  = (state_q == S_RUN);
    assign done  = done_q;
    assign s     = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Bench for seq_ripple_adder: three instances (CHUNK=4, 1, 16) checked against an arithmetic model.
// Latency: measured per operation in clock cycles from the accepting edge to done.
// Backpressure: exercises ignored start during RUN, back-to-back start in the done cycle and mid-run reset.
module tb_seq_ripple_adder;

    localparam int W = 16;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_r;
    logic [1:0]   sel;
    logic [W-1:0] a_r, b_r;
    logic         ci_r;

    logic         start4, start1, start16;
    logic         busy4, done4, cout4, ovf4;
    logic         busy1, done1, cout1, ovf1;
    logic         busy16, done16, cout16, ovf16;
    logic [W-1:0] s4, s1, s16;

    assign start4  = start_r && (sel == 2'd0);
    assign start1  = start_r && (sel == 2'd1);
    assign start16 = start_r && (sel == 2'd2);

    seq_ripple_adder #(.WIDTH(W), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .start(start4), .a(a_r), .b(b_r), .c_in(ci_r),
        .busy(busy4), .done(done4), .s(s4), .c_out(cout4), .ovf(ovf4));

    seq_ripple_adder #(.WIDTH(W), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a_r), .b(b_r), .c_in(ci_r),
        .busy(busy1), .done(done1), .s(s1), .c_out(cout1), .ovf(ovf1));

    seq_ripple_adder #(.WIDTH(W), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a_r), .b(b_r), .c_in(ci_r),
        .busy(busy16), .done(done16), .s(s16), .c_out(cout16), .ovf(ovf16));

    // Outputs of the instance currently selected.
    logic         o_busy, o_done, o_cout, o_ovf;
    logic [W-1:0] o_s;
    always_comb begin
        o_busy = busy4; o_done = done4; o_cout = cout4; o_ovf = ovf4; o_s = s4;
        case (sel)
            2'd1:    begin o_busy = busy1;  o_done = done1;  o_cout = cout1;  o_ovf = ovf1;  o_s = s1;  end
            2'd2:    begin o_busy = busy16; o_done = done16; o_cout = cout16; o_ovf = ovf16; o_s = s16; end
            default: begin end
        endcase
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, c_out, s} from plain unsigned and signed arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int   u;
        int   sg;
        logic ov;
        u  = int'(x) + int'(y) + int'(ci);
        sg = int'($signed(x)) + int'($signed(y)) + int'(ci);
        ov = (sg > 32767) || (sg < -32768);
        return {ov & OVF_ON, u[16], u[15:0]};
    endfunction

    function automatic int lat_of(input logic [1:0] which);
        case (which)
            2'd1:    return 16;
            2'd2:    return 1;
            default: return 4;
        endcase
    endfunction

    // Present operands with start for one edge, then scramble the inputs.
    task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic ci);
        a_r = x; b_r = y; ci_r = ci; start_r = 1'b1;
        tick;
        start_r = 1'b0;
        a_r = 16'($urandom); b_r = 16'($urandom); ci_r = 1'($urandom);
    endtask

    // Wait (bounded) for done; returns in the done cycle.
    task automatic wait_done(input string tag, input int lat_exp,
                             input logic [15:0] x, input logic [15:0] y, input logic ci);
        int          lat;
        int          gaps;
        logic [17:0] m;
        lat  = 0;
        gaps = 0;
        m    = model(x, y, ci);
        while (o_done !== 1'b1 && lat < lat_exp + 8) begin
            if (o_busy !== 1'b1) gaps++;
            tick;
            lat++;
        end
        check({tag, "_lat"},   lat,    lat_exp);
        check({tag, "_gaps"},  gaps,   0);
        check({tag, "_done"},  o_done, 1'b1);
        check({tag, "_busy"},  o_busy, 1'b0);
        check({tag, "_s"},     o_s,    m[15:0]);
        check({tag, "_cout"},  o_cout, m[16]);
        check({tag, "_ovf"},   o_ovf,  m[17]);
    endtask

    task automatic full_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic ci);
        start_op(x, y, ci);
        wait_done(tag, lat_of(sel), x, y, ci);
        tick;
        check({tag, "_pulse"}, o_done, 1'b0);
    endtask

    initial begin
        int          t_first;
        int          spurious;
        logic [15:0] ra, rb;
        logic        rci;

        rst = 1'b1; start_r = 1'b0; sel = 2'd0; a_r = '0; b_r = '0; ci_r = 1'b0;
        tick; tick;
        // Reset state of every instance.
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #0;
            check("rst_busy", o_busy, 1'b0);
            check("rst_done", o_done, 1'b0);
            check("rst_s",    o_s,    16'h0000);
            check("rst_cout", o_cout, 1'b0);
            check("rst_ovf",  o_ovf,  1'b0);
        end
        sel = 2'd0;
        rst = 1'b0;
        tick;

        // Full-width carry propagation.
        full_op("t2", 16'hFFFF, 16'h0001, 1'b0);

        // Back-to-back: start held in the done cycle.
        start_op(16'h1234, 16'h4321, 1'b1);
        wait_done("t3a", 4, 16'h1234, 16'h4321, 1'b1);
        t_first = cyc;
        start_op(16'h00FF, 16'h0001, 1'b0);
        wait_done("t3b", 4, 16'h00FF, 16'h0001, 1'b0);
        check("t3_spacing", cyc - t_first, 5);
        tick;

        // Start during RUN is ignored.
        start_op(16'h0F0F, 16'h0101, 1'b0);
        a_r = 16'hFFFF; start_r = 1'b1;
        tick;
        start_r = 1'b0;
        wait_done("t4", 3, 16'h0F0F, 16'h0101, 1'b0);
        spurious = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (o_done !== 1'b0 || o_busy !== 1'b0) spurious++;
        end
        check("t4_no_queue", spurious, 0);

        // Reset mid-computation aborts without done.
        start_op(16'hAAAA, 16'h5555, 1'b1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("t5_busy", o_busy, 1'b0);
        check("t5_done", o_done, 1'b0);
        check("t5_s",    o_s,    16'h0000);
        check("t5_cout", o_cout, 1'b0);
        spurious = 0;
        for (int k = 0; k < 8; k++) begin
            if (o_done !== 1'b0) spurious++;
            tick;
        end
        check("t5_no_done", spurious, 0);
        full_op("t5_next", 16'h0001, 16'h0001, 1'b0);

        // Signed overflow boundaries.
        full_op("t6_ovf",   16'h7FFF, 16'h0001, 1'b0);
        full_op("t6_noovf", 16'hFFFF, 16'h0001, 1'b0);
        full_op("t6_neg",   16'h8000, 16'hFFFF, 1'b0);

        // Random operations on the CHUNK=4 instance.
        for (int k = 0; k < 20; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
            full_op("rnd4", ra, rb, rci);
        end

        // CHUNK=1 and CHUNK=16 instances.
        sel = 2'd1;
        full_op("c1_t2", 16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
            full_op("rnd1", ra, rb, rci);
        end
        sel = 2'd2;
        full_op("c16_t2", 16'hFFFF, 16'h0001, 1'b0);
        full_op("c16_ovf", 16'h7FFF, 16'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
            full_op("rnd16", ra, rb, rci);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_ripple_adder.md
Name: seq_ripple_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, low chunk first.
- Each chunk is a CHUNK-bit ripple of full-adder cells, and a carry register links the chunks between cycles.
- Trades latency for area in datapaths where a full-width ripple misses timing; start/busy/done handshake toward the controlling FSM.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK, and at least 2.
CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH.
(Derived) N = WIDTH/CHUNK, number of compute cycles; chunk counter width = clog2(N), minimum 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A; captured when start is accepted
b  input  WIDTH  operand B; captured when start is accepted
c_in  input  1  carry-in; captured when start is accepted
busy  output  1  high while a computation is in progress
done  output  1  one-cycle pulse; s/c_out valid
s  output  WIDTH  sum, registered
c_out  output  1  carry out of bit WIDTH-1, registered
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset: when rst=1 at a clock edge, the FSM goes to IDLE; busy=0, done=0, s=0, c_out=0, ovf=0, and the internal carry and chunk counter clear. This takes priority over all other inputs, including mid-computation. An aborted operation produces no done pulse.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start=1 at edge k: latch a, b and c_in into operand registers; carry register = c_in; counter = 0; go to RUN.
  - busy is high from after edge k.
  - start=0: stay in IDLE.
- RUN, at each edge:
  - Compute {carry, s[i*CHUNK +: CHUNK]} = a_r[chunk i] + b_r[chunk i] + carry, where i = counter.
  - Per-bit logic: s = a^b^c; c_out = (a^b)&c | a&b.
  - Write the chunk into its slice of the sum register, then increment the counter.
  - Final chunk (i = N-1), written at edge k+N: c_out = final carry; done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: start accepted at edge k -> done high in the cycle following edge k+N. With defaults this is 4 cycles.
- start while busy=1 is ignored, with no queueing. Operand inputs may change freely after acceptance.
- start=1 during the done cycle is accepted, because busy=0 then. This gives back-to-back operation with a throughput of one result per N+1 cycles.
- Outputs s, c_out and ovf hold the last completed result until the next done.
  - Partial slices of s update during RUN and are not valid until done.
- CHUNK=WIDTH degenerates to N=1: single-cycle compute, with done the cycle after acceptance.
- Wrap-around: the sum is modulo 2^WIDTH; the carry-out is reported on c_out only.

Optional Feature:
- Macro: SEQ_RIPPLE_ADDER_OVF_EN.
- Defined:
  - Capture the carry into bit WIDTH-1 (c_msb_in) during the final chunk.
  - ovf = c_msb_in ^ c_out, registered, and updated in the same edge as done.
  - Reset value 0.
- Undefined: ovf is tied to constant 0, no extra logic. The port remains so the interface is stable.

Test Plan:
1. Defaults: rst high for 2 cycles -> busy=0, done=0, s=0x0000, c_out=0, ovf=0.
2. start with a=0xFFFF, b=0x0001, c_in=0 -> done exactly 4 cycles after acceptance with s=0x0000, c_out=1, busy high for those 4 cycles.
3. a=0x1234, b=0x4321, c_in=1 -> s=0x5556, c_out=0. Then, with start held high in the done cycle and new a=0x00FF, b=0x0001, c_in=0 -> second done 5 cycles after the first, s=0x0100, c_out=0.
4. start with a=0x0F0F, b=0x0101, then pulse start again with a=0xFFFF mid-RUN -> second start ignored; the single done reports s=0x1010, c_out=0.
5. start with a=0xAAAA, b=0x5555, c_in=1; assert rst 2 cycles after acceptance -> busy=0, s=0, no done pulse. The next operation, 0x0001+0x0001, gives s=0x0002.
6. SEQ_RIPPLE_ADDER_OVF_EN defined: 0x7FFF+0x0001 -> s=0x8000, c_out=0, ovf=1; 0xFFFF+0x0001 -> ovf=0. Macro undefined: ovf stays 0 for both. Repeat test 2 with CHUNK=1 (done after 16 cycles) and CHUNK=16 (done after 1 cycle).
